// File: rtl/vga_read_scheduler.sv
// Port V read scheduler: paces SDRAM reads against the output FIFO and owns the double-buffered frame base.
// Optional build macro VGA_SCHED_STATS_EN adds a saturating null-pixel counter output (null_count).
module vga_read_scheduler #(
  parameter int FRAME_PIXELS = 307200,
  parameter int MAX_INFLIGHT = 16,
  parameter int FIFO_HIGH    = 448,
  parameter int RESYNC_LEAD  = 8
) (
  input  logic        clk,
  input  logic        portV_arst,
  input  logic        enable,
  input  logic [24:0] frame_base,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic [24:0] readOffset,
  output logic        rd_req,
  output logic [24:0] rd_addr,
  input  logic        rd_ack,
  input  logic        readValid,
  input  logic        PortVout_wrreq,
  input  logic        PortVout_nullData,
  input  logic [8:0]  PortVout_usedw
`ifdef VGA_SCHED_STATS_EN
  ,
  output logic [15:0] null_count
`endif
);

  localparam int PIX_W = $clog2(FRAME_PIXELS);
  localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [PIX_W-1:0] req_pix;
  logic [PIX_W-1:0] exp_pix;
  logic [PIX_W-1:0] resync_pix;
  logic [PIX_W-1:0] req_pix_inc;
  logic [PIX_W-1:0] exp_pix_inc;
  logic [PIX_W-1:0] resync_target;
  logic [INF_W-1:0] inflight;
  logic [24:0]      pending_base;
  logic             swap_pending;
  logic             resync_pending;
  logic             accept;
  logic             null_wr;
  logic             credit_ok;
  logic [9:0]       fill_sum;
  logic [31:0]      resync_sum;

  assign accept      = rd_req & rd_ack;
  assign null_wr     = PortVout_wrreq & PortVout_nullData;
  assign req_pix_inc = (req_pix == LAST_PIX) ? '0 : req_pix + PIX_W'(1);
  assign exp_pix_inc = (exp_pix == LAST_PIX) ? '0 : exp_pix + PIX_W'(1);

  // Credit check: FIFO fill plus reads already promised must stay below the high mark.
  assign fill_sum  = {1'b0, PortVout_usedw} + 10'(inflight);
  assign credit_ok = (inflight < INF_W'(MAX_INFLIGHT)) && (fill_sum < 10'(FIFO_HIGH));

  // Re-aim just past the pixel the tracker is currently writing, plus a lead.
  assign resync_sum    = 32'(exp_pix) + 32'(RESYNC_LEAD) + 32'd1;
  assign resync_target = (resync_sum >= 32'(FRAME_PIXELS)) ? PIX_W'(resync_sum - 32'(FRAME_PIXELS))
                                                           : PIX_W'(resync_sum);

  // NOTE: all state below uses non-blocking assignments so every block samples pre-edge values.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      inflight <= '0;
    end else begin
      unique case ({accept, readValid})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - INF_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      exp_pix <= '0;
    end else if (PortVout_wrreq) begin
      exp_pix <= exp_pix_inc;
    end
  end

  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      state          <= IDLE;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      readOffset     <= '0;
      swap_ack       <= 1'b0;
      req_pix        <= '0;
      resync_pix     <= '0;
      pending_base   <= '0;
      swap_pending   <= 1'b0;
      resync_pending <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (rd_req) begin
            // Request is frozen until accepted; a null write now is remembered for after the ack.
            if (null_wr) begin
              resync_pending <= 1'b1;
              resync_pix     <= resync_target;
            end
            if (rd_ack) begin
              rd_req <= 1'b0;
              if (req_pix == LAST_PIX && swap_pending) begin
                state          <= DRAIN;
                req_pix        <= '0;
                resync_pending <= 1'b0;
              end else if (null_wr) begin
                req_pix        <= resync_target;
                resync_pending <= 1'b0;
              end else if (resync_pending) begin
                req_pix        <= resync_pix;
                resync_pending <= 1'b0;
              end else begin
                req_pix <= req_pix_inc;
              end
            end
          end else if (!enable) begin
            state <= IDLE;
          end else if (null_wr) begin
            req_pix <= resync_target;
          end else if (credit_ok) begin
            rd_req  <= 1'b1;
            rd_addr <= readOffset + 25'(req_pix);
          end
        end
        DRAIN: begin
          // Swap only once every old-frame read is back and the tracker has wrapped.
          if (inflight == '0 && exp_pix == '0) begin
            state        <= RUN;
            readOffset   <= pending_base;
            swap_ack     <= 1'b1;
            swap_pending <= 1'b0;
            req_pix      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      if (swap_req) begin
        pending_base <= frame_base;
        swap_pending <= 1'b1;
      end
    end
  end

`ifdef VGA_SCHED_STATS_EN
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      null_count <= '0;
    end else if (swap_ack) begin
      null_count <= '0;
    end else if (null_wr && null_count != 16'hFFFF) begin
      null_count <= null_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_read_scheduler.sv
// Directed bench for vga_read_scheduler; a reduced frame size keeps the frame-wrap and swap paths short.
module tb_vga_read_scheduler;

  localparam int FRAME_PIXELS = 256;

  logic        clk;
  logic        portV_arst;
  logic        enable;
  logic [24:0] frame_base;
  logic        swap_req;
  logic        swap_ack;
  logic [24:0] readOffset;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_ack;
  logic        readValid;
  logic        PortVout_wrreq;
  logic        PortVout_nullData;
  logic [8:0]  PortVout_usedw;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  vga_read_scheduler #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .MAX_INFLIGHT(16),
    .FIFO_HIGH   (448),
    .RESYNC_LEAD (8)
  ) dut (
    .clk              (clk),
    .portV_arst       (portV_arst),
    .enable           (enable),
    .frame_base       (frame_base),
    .swap_req         (swap_req),
    .swap_ack         (swap_ack),
    .readOffset       (readOffset),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_ack           (rd_ack),
    .readValid        (readValid),
    .PortVout_wrreq   (PortVout_wrreq),
    .PortVout_nullData(PortVout_nullData),
    .PortVout_usedw   (PortVout_usedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int   n_req;
    logic prev;
    logic b2b;
    logic found;

    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    portV_arst = 1'b1; enable = 1'b0; frame_base = '0; swap_req = 1'b0;
    rd_ack = 1'b0; readValid = 1'b0; PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
    PortVout_usedw = '0;

    // Reset state
    tick(); tick();
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_readOffset", 32'(readOffset), 32'd0);
    check("rst_swap_ack", 32'(swap_ack), 32'd0);
    portV_arst = 1'b0;

    // Free-running acks, no returns: credit limit stops at 16 requests
    enable = 1'b1; rd_ack = 1'b1;
    n_req = 0; prev = 1'b0; b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rd_req) begin
        check("burst_addr", 32'(rd_addr), 32'(n_req));
        n_req++;
      end
      if (rd_req && prev) b2b = 1'b1;
      prev = rd_req;
    end
    check("burst_count", 32'(n_req), 32'd16);
    check("no_back_to_back", 32'(b2b), 32'd0);

    // Return 8 reads: inflight 8; FIFO boundary 440+8 blocks, 432+8 issues
    rd_ack = 1'b0; PortVout_usedw = 9'd448; readValid = 1'b1;
    repeat (8) tick();
    readValid = 1'b0; PortVout_usedw = 9'd440;
    tick();
    check("fill_440_8_a", 32'(rd_req), 32'd0);
    tick();
    check("fill_440_8_b", 32'(rd_req), 32'd0);
    PortVout_usedw = 9'd432;
    tick();
    check("fill_432_8", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd16}));

    // Held request stays stable while the credit condition lapses
    for (int i = 1; i <= 5; i++) begin
      PortVout_usedw = 9'(440 + i * 12);
      tick();
      check("hold_stable", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd16}));
    end
    rd_ack = 1'b1;
    tick();
    check("hold_ack_drop", 32'(rd_req), 32'd0);
    rd_ack = 1'b0;

    // inflight 9 -> 7; 441+7 hits the mark exactly
    readValid = 1'b1;
    tick(); tick();
    readValid = 1'b0; PortVout_usedw = 9'd441;
    tick();
    check("fill_441_7", 32'(rd_req), 32'd0);

    // Resync with rd_req low: exp_pix 100 -> target 109
    PortVout_usedw = 9'd448; PortVout_wrreq = 1'b1;
    repeat (100) tick();
    PortVout_nullData = 1'b1; PortVout_usedw = 9'd0;
    tick();
    check("resync_no_issue_on_trigger", 32'(rd_req), 32'd0);
    PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
    tick();
    check("resync_low_addr", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd109}));

    // Resync while held: exp_pix 120 at trigger -> 129 used after ack
    PortVout_wrreq = 1'b1;
    repeat (19) tick();
    PortVout_nullData = 1'b1;
    tick();
    PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
    check("resync_held_stable", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd109}));
    rd_ack = 1'b1;
    tick();
    check("resync_held_ack", 32'(rd_req), 32'd0);
    rd_ack = 1'b0;
    tick();
    check("resync_held_addr", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd129}));

    // Simultaneous ack + return keeps inflight at 8: 440 blocks, 439 issues
    rd_ack = 1'b1; readValid = 1'b1; PortVout_usedw = 9'd440;
    tick();
    rd_ack = 1'b0; readValid = 1'b0;
    tick();
    check("ack_valid_440", 32'(rd_req), 32'd0);
    PortVout_usedw = 9'd439;
    tick();
    check("ack_valid_439", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd130}));

    // Drain inflight to 0 with extra returns; 447+0 must still issue
    rd_ack = 1'b1; PortVout_usedw = 9'd448;
    tick();
    rd_ack = 1'b0; readValid = 1'b1;
    repeat (12) tick();
    readValid = 1'b0; PortVout_usedw = 9'd447;
    tick();
    check("inflight_floor", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd131}));

    // Two swap requests; the second base wins
    frame_base = 25'h0AAAAA; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    frame_base = 25'h100000; swap_req = 1'b1;
    tick();
    swap_req = 1'b0; frame_base = '0;
    rd_ack = 1'b1; readValid = 1'b1; PortVout_usedw = 9'd0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rd_req === 1'b1 && rd_addr === 25'd255) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_last_pixel", 32'(found), 32'd1);
    readValid = 1'b0;
    tick();
    check("wrap_enter_drain", 32'(rd_req), 32'd0);
    rd_ack = 1'b0;
    tick(); tick(); tick();
    check("drain_no_issue", 32'(rd_req), 32'd0);
    check("drain_offset_old", 32'(readOffset), 32'd0);

    // Tracker runs 121 -> 0 with null pixels; one read still outstanding
    PortVout_wrreq = 1'b1; PortVout_nullData = 1'b1;
    repeat (135) tick();
    PortVout_wrreq = 1'b0; PortVout_nullData = 1'b0;
    tick(); tick();
    check("drain_wait_inflight_ack", 32'(swap_ack), 32'd0);
    check("drain_wait_inflight_off", 32'(readOffset), 32'd0);
    readValid = 1'b1;
    tick();
    check("drain_last_return", 32'(swap_ack), 32'd0);
    readValid = 1'b0;
    tick();
    check("swap_ack_pulse", 32'(swap_ack), 32'd1);
    check("swap_offset", 32'(readOffset), 32'h100000);
    check("swap_rd_req_low", 32'(rd_req), 32'd0);
    tick();
    check("swap_ack_single", 32'(swap_ack), 32'd0);
    check("swap_first_addr", 32'({rd_req, rd_addr}), 32'({1'b1, 25'h100000}));

    // Second frame into DRAIN, then async reset mid-DRAIN
    frame_base = 25'h1ABCDE; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rd_ack = 1'b1; readValid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rd_req === 1'b1 && rd_addr === 25'h1000FF) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_last_pixel_2", 32'(found), 32'd1);
    readValid = 1'b0;
    tick();
    rd_ack = 1'b0;
    tick();
    check("drain2_no_issue", 32'(rd_req), 32'd0);
    check("drain2_offset", 32'(readOffset), 32'h100000);
    #3 portV_arst = 1'b1;
    #1;
    check("arst_readOffset", 32'(readOffset), 32'd0);
    check("arst_rd_addr", 32'(rd_addr), 32'd0);
    check("arst_rd_req", 32'(rd_req), 32'd0);
    check("arst_swap_ack", 32'(swap_ack), 32'd0);
    tick();
    portV_arst = 1'b0;

    // Reset mid-handshake drops rd_req at once
    tick(); tick();
    check("post_rst_req", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd0}));
    #3 portV_arst = 1'b1;
    #1;
    check("arst_mid_handshake", 32'(rd_req), 32'd0);
    tick();
    portV_arst = 1'b0; enable = 1'b0; readValid = 1'b1;
    tick(); tick();
    readValid = 1'b0; PortVout_usedw = 9'd447; enable = 1'b1;
    tick(); tick();
    check("late_returns_ignored", 32'({rd_req, rd_addr}), 32'({1'b1, 25'd0}));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
